// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control unit: FSM states,
// instruction fields, ALU operation codes, datapath select values and the
// bundle of control outputs driven each cycle.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC_R,
      ALUWB,
      EXEC_I,
      IWB,
      BRANCH,
      JUMP,
      HALT
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Register-file destination select
   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Every control output of the FSM, built as one value per cycle
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       memto_reg;
      logic       alu_src_a;
      logic       link;
      logic [1:0] reg_dst;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
      logic       retire;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/mc_funct_decoder.sv
// Maps the R-type funct field to an ALU operation and flags whether the
// funct is one this core implements.
module mc_funct_decoder
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       legal
);

   // Table lookup of supported funct codes; unsupported ones default to add
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      alu_control = ALU_ADD;
      legal       = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_SLT:  alu_control = ALU_SLT;
         default: legal       = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Control unit for a multi-cycle processor with a single unified memory.
// Sequences fetch, decode, execute, memory and write-back steps and drives
// the datapath enables/selects for each step. Outputs are a function of the
// current state plus the live mem_ready/zero/opcode inputs; reset forces
// every output low in the same cycle so no write can escape an abandoned
// instruction.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       memto_reg,
   output logic       alu_src_a,
   output logic       link,
   output logic [1:0] reg_dst,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control,
   output logic       retire,
   output logic       halted
);

   state_t     state;
   state_t     next_state;
   state_t     illegal_next;
   ctrl_t      ctrl;
   logic [2:0] funct_alu;
   logic       funct_legal;

   mc_funct_decoder u_funct_decoder (
      .funct       (funct),
      .alu_control (funct_alu),
      .legal       (funct_legal)
   );

   // Unsupported instructions either park the core or fall back to fetch
   // without retiring (a NOP that does not count as a completed instruction).
   assign illegal_next = ILLEGAL_HALT ? HALT : FETCH;

   // State register with synchronous reset back to FETCH
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Next-state selection; memory states hold until mem_ready
   always_comb begin
      next_state = state;
      case (state)
         FETCH:  if (mem_ready) next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     next_state = MEMADR;
               OP_RTYPE:         next_state = funct_legal ? EXEC_R : illegal_next;
               OP_ADDI, OP_ANDI: next_state = EXEC_I;
               OP_BEQ, OP_BNE:   next_state = BRANCH;
               OP_J, OP_JAL:     next_state = JUMP;
               default:          next_state = illegal_next;
            endcase
         end
         MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (mem_ready) next_state = MEMWB;
         MEMWB:  next_state = FETCH;
         MEMWR:  if (mem_ready) next_state = FETCH;
         EXEC_R: next_state = ALUWB;
         ALUWB:  next_state = FETCH;
         EXEC_I: next_state = IWB;
         IWB:    next_state = FETCH;
         BRANCH: next_state = FETCH;
         JUMP:   next_state = FETCH;
         HALT:   next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   // Per-state control outputs; everything not set here stays 0, and reset
   // overrides the state so no enable or request leaks during the reset cycle
   always_comb begin
      ctrl = '0;
      if (!reset) begin
         case (state)
            FETCH: begin
               ctrl.mem_req     = 1'b1;
               ctrl.alu_src_b   = SRCB_FOUR;
               ctrl.alu_control = ALU_ADD;
               if (mem_ready) begin
                  ctrl.ir_write = 1'b1;
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = PCSRC_ALU;
               end
            end
            DECODE: begin
               // Precompute the branch target while the register file is read
               ctrl.alu_src_b   = SRCB_IMM_SH;
               ctrl.alu_control = ALU_ADD;
            end
            MEMADR: begin
               ctrl.alu_src_a   = 1'b1;
               ctrl.alu_src_b   = SRCB_IMM;
               ctrl.alu_control = ALU_ADD;
            end
            MEMRD: begin
               ctrl.mem_req = 1'b1;
               ctrl.i_or_d  = 1'b1;
            end
            MEMWB: begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = REGDST_RT;
               ctrl.memto_reg = 1'b1;
               ctrl.retire    = 1'b1;
            end
            MEMWR: begin
               ctrl.mem_req = 1'b1;
               ctrl.mem_we  = 1'b1;
               ctrl.i_or_d  = 1'b1;
               ctrl.retire  = mem_ready;
            end
            EXEC_R: begin
               ctrl.alu_src_a   = 1'b1;
               ctrl.alu_src_b   = SRCB_B;
               ctrl.alu_control = funct_alu;
            end
            ALUWB: begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = REGDST_RD;
               ctrl.retire    = 1'b1;
            end
            EXEC_I: begin
               ctrl.alu_src_a   = 1'b1;
               ctrl.alu_src_b   = SRCB_IMM;
               ctrl.alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            IWB: begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = REGDST_RT;
               ctrl.retire    = 1'b1;
            end
            BRANCH: begin
               // ALUOut holds the target computed in DECODE; the compare
               // result decides whether it is taken
               ctrl.alu_src_a   = 1'b1;
               ctrl.alu_src_b   = SRCB_B;
               ctrl.alu_control = ALU_SUB;
               ctrl.pc_src      = PCSRC_ALUOUT;
               ctrl.pc_write    = (opcode == OP_BNE) ? ~zero : zero;
               ctrl.retire      = 1'b1;
            end
            JUMP: begin
               ctrl.pc_src   = PCSRC_JUMP;
               ctrl.pc_write = 1'b1;
               ctrl.retire   = 1'b1;
               if (opcode == OP_JAL) begin
                  ctrl.reg_write = 1'b1;
                  ctrl.reg_dst   = REGDST_R31;
                  ctrl.link      = 1'b1;
               end
            end
            HALT:    ctrl.halted = 1'b1;
            default: ctrl = '0;
         endcase
      end
   end

   assign mem_req     = ctrl.mem_req;
   assign mem_we      = ctrl.mem_we;
   assign i_or_d      = ctrl.i_or_d;
   assign ir_write    = ctrl.ir_write;
   assign pc_write    = ctrl.pc_write;
   assign reg_write   = ctrl.reg_write;
   assign memto_reg   = ctrl.memto_reg;
   assign alu_src_a   = ctrl.alu_src_a;
   assign link        = ctrl.link;
   assign reg_dst     = ctrl.reg_dst;
   assign alu_src_b   = ctrl.alu_src_b;
   assign pc_src      = ctrl.pc_src;
   assign alu_control = ctrl.alu_control;
   assign retire      = ctrl.retire;
   assign halted      = ctrl.halted;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. For each instruction a reference
// model expands the instruction class and chosen memory wait counts into the
// expected per-cycle control outputs; the bench then plays that script into
// the DUT and compares every cycle. Directed cases are followed by random
// instruction streams with random waits, illegal opcodes and mid-instruction
// resets.
module tb_mc_control_fsm;

   // Expected/observed control bundle, field order fixed by this bench
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       memto_reg;
      logic       alu_src_a;
      logic       link;
      logic [1:0] reg_dst;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
      logic       retire;
      logic       halted;
   } out_t;

   typedef struct {
      out_t        exp;
      logic        mr;
      logic        z;
      logic [5:0]  op;
      logic [5:0]  fn;
      string       tag;
   } step_t;

   typedef enum {K_LW, K_SW, K_R, K_I, K_BR, K_J, K_ILL} kind_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
   logic       memto_reg, alu_src_a, link, retire, halted;
   logic [1:0] reg_dst, alu_src_b, pc_src;
   logic [2:0] alu_control;
   out_t       obs;

   int test_count = 0;
   int fail_count = 0;
   int instr_id   = 0;
   step_t steps[$];

   mc_control_fsm #(.ILLEGAL_HALT(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .i_or_d      (i_or_d),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .memto_reg   (memto_reg),
      .alu_src_a   (alu_src_a),
      .link        (link),
      .reg_dst     (reg_dst),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control),
      .retire      (retire),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write,
                 memto_reg, alu_src_a, link, reg_dst, alu_src_b, pc_src,
                 alu_control, retire, halted};

   task automatic check(input string tag, input out_t got, input out_t exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b101010}) ? K_R : K_ILL;
         6'b001000, 6'b001100: return K_I;
         6'b000100, 6'b000101: return K_BR;
         6'b000010, 6'b000011: return K_J;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   task automatic push(input out_t e, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input string ph);
      step_t s;
      s.exp = e; s.mr = mr; s.z = z; s.op = op; s.fn = fn;
      s.tag = $sformatf("i%0d.%s", instr_id, ph);
      steps.push_back(s);
   endtask

   // Expand one instruction into its expected cycle-by-cycle script
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int fetch_waits, input int mem_waits);
      out_t  e;
      kind_t k = classify(op, fn);
      instr_id++;
      // fetch: IR not yet loaded, so opcode/funct are garbage here
      for (int i = 0; i <= fetch_waits; i++) begin
         e = '0; e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
         if (i == fetch_waits) begin e.ir_write = 1; e.pc_write = 1; end
         push(e, (i == fetch_waits), 1'($urandom), 6'($urandom), 6'($urandom), "fetch");
      end
      e = '0; e.alu_src_b = 2'b11; e.alu_control = 3'b010;
      push(e, 1'($urandom), 1'($urandom), op, fn, "decode");
      case (k)
         K_LW, K_SW: begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
            push(e, 1'($urandom), 1'($urandom), op, fn, "memadr");
            for (int i = 0; i <= mem_waits; i++) begin
               e = '0; e.mem_req = 1; e.i_or_d = 1;
               if (k == K_SW) begin
                  e.mem_we = 1;
                  e.retire = (i == mem_waits);
               end
               push(e, (i == mem_waits), 1'($urandom), op, fn, "mem");
            end
            if (k == K_LW) begin
               e = '0; e.reg_write = 1; e.memto_reg = 1; e.retire = 1;
               push(e, 1'($urandom), 1'($urandom), op, fn, "memwb");
            end
         end
         K_R: begin
            e = '0; e.alu_src_a = 1; e.alu_control = r_alu(fn);
            push(e, 1'($urandom), 1'($urandom), op, fn, "exec_r");
            e = '0; e.reg_write = 1; e.reg_dst = 2'b01; e.retire = 1;
            push(e, 1'($urandom), 1'($urandom), op, fn, "aluwb");
         end
         K_I: begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
            e.alu_control = (op == 6'b001100) ? 3'b000 : 3'b010;
            push(e, 1'($urandom), 1'($urandom), op, fn, "exec_i");
            e = '0; e.reg_write = 1; e.retire = 1;
            push(e, 1'($urandom), 1'($urandom), op, fn, "iwb");
         end
         K_BR: begin
            e = '0; e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01;
            e.pc_write = (op == 6'b000100) ? z : ~z; e.retire = 1;
            push(e, 1'($urandom), z, op, fn, "branch");
         end
         K_J: begin
            e = '0; e.pc_src = 2'b10; e.pc_write = 1; e.retire = 1;
            if (op == 6'b000011) begin e.reg_write = 1; e.reg_dst = 2'b10; e.link = 1; end
            push(e, 1'($urandom), 1'($urandom), op, fn, "jump");
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               e = '0; e.halted = 1;
               push(e, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), "halt");
            end
         end
      endcase
   endtask

   // ---------------- drivers ----------------
   task automatic run_steps(input int limit);
      int n = 0;
      step_t s;
      while (steps.size() > 0 && (limit < 0 || n < limit)) begin
         s = steps.pop_front();
         @(posedge clk); #1;
         reset = 1'b0; mem_ready = s.mr; zero = s.z; opcode = s.op; funct = s.fn;
         #1;
         check(s.tag, obs, s.exp);
         n++;
      end
      steps.delete();
   endtask

   task automatic pulse_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         reset = 1'b1; mem_ready = 1'($urandom); zero = 1'($urandom);
         opcode = 6'($urandom); funct = 6'($urandom);
         #1;
         check($sformatf("i%0d.reset", instr_id), obs, '0);
      end
   endtask

   initial begin
      logic [5:0] legal_ops [9];
      logic [5:0] legal_fns [5];
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                    6'b000100, 6'b000101, 6'b000010, 6'b000011};
      legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      pulse_reset(2);

      // add, zero waits: retire in cycle 4
      build(6'b000000, 6'b100000, 1'b0, 0, 0); run_steps(-1);
      // lw with two memory wait cycles: retire in cycle 7
      build(6'b100011, 6'b000000, 1'b0, 0, 2); run_steps(-1);
      // beq taken, bne not taken, both with zero=1
      build(6'b000100, 6'b000000, 1'b1, 0, 0); run_steps(-1);
      build(6'b000101, 6'b000000, 1'b1, 0, 0); run_steps(-1);
      // jal
      build(6'b000011, 6'b000000, 1'b0, 0, 0); run_steps(-1);
      // illegal opcode parks in HALT until reset; fetch resumes afterwards
      build(6'b111111, 6'b000000, 1'b0, 0, 0); run_steps(-1);
      pulse_reset(1);
      build(6'b001000, 6'b000000, 1'b0, 1, 0); run_steps(-1);
      // reset during a stalled sw: fetch, decode, memadr, one wait, then reset
      build(6'b101011, 6'b000000, 1'b0, 0, 3); run_steps(4);
      pulse_reset(1);
      build(6'b000010, 6'b000000, 1'b0, 0, 0); run_steps(-1);

      // random instruction stream
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         int         limit;
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
         fn = ($urandom_range(0, 6) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
         build(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
         limit = -1;
         if ($urandom_range(0, 9) == 0) limit = $urandom_range(1, steps.size() - 1);
         run_steps(limit);
         if (limit >= 0 || classify(op, fn) == K_ILL) pulse_reset($urandom_range(1, 2));
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
